bit_scan_counter: RTL and testbench
===================================

BIT_SCAN_COUNTER -- requirements
Module: bit_scan_counter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning the operand width in bits; legal values are 4..64.
REQ-002 The block SHALL have parameter BPC, default 1, meaning the bits examined per SCAN cycle; it must be 1, 2 or 4 and divide DATA_W.
REQ-003 The block SHALL have parameter CNT_W, default $clog2(DATA_W+1), meaning the result width.
REQ-004 The block SHALL have port CLK, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port Reset, input, 1 bit, reset that is synchronous and active-high.
REQ-006 The block SHALL have port Start, input, 1 bit, the request to begin an operation.
REQ-007 The block SHALL have port Mode, input, 2 bits: 00 count ones, 01 count zeros, 10 leading zeros (MSB first), 11 trailing zeros (LSB first).
REQ-008 The block SHALL have port DataIn, input, DATA_W bits, the operand.
REQ-009 The block SHALL have port Busy, output, 1 bit, high in states SCAN and DONE.
REQ-010 The block SHALL have port Done, output, 1 bit, a one-cycle result-valid pulse.
REQ-011 The block SHALL have port Count, output, CNT_W bits, the result, held until the next accepted Start.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SCAN and DONE.
REQ-013 In IDLE with Start=1, the block SHALL capture DataIn into the shift register and Mode into the mode register, clear Count, and enter SCAN.
REQ-014 Start SHALL be ignored in SCAN and DONE; DataIn and Mode changes after capture SHALL have no effect.
REQ-015 Each SCAN cycle SHALL process one BPC-bit chunk: the low chunk with a right shift for modes 00, 01 and 11, and the high chunk with a left shift for mode 10.
REQ-016 In mode 00, Count SHALL add the popcount of the chunk.
REQ-017 In mode 01, Count SHALL add BPC minus the popcount of the chunk.
REQ-018 In modes 10 and 11, Count SHALL add the number of zeros before the first 1 in scan order within the chunk.
REQ-019 SCAN SHALL exit to DONE after the cycle in which DATA_W/BPC chunks have been processed.
REQ-020 In mode 00, SCAN SHALL also exit early after any cycle whose post-shift register is all-zero.
REQ-021 In modes 10 and 11, SCAN SHALL also exit early after any cycle whose chunk contains a 1.
REQ-022 Mode 01 SHALL have no early exit.
REQ-023 Latency SHALL be defined as follows: Start is accepted at edge 0, SCAN occupies cycles 1..N (1 <= N <= DATA_W/BPC), and Done=1 in cycle N+1 only.
REQ-024 DONE SHALL last exactly one cycle and then return to IDLE; a Start in that cycle is ignored.
REQ-025 An all-zero operand SHALL give Count=DATA_W in modes 01, 10 and 11, and Count=0 with N=1 in mode 00.
REQ-026 Count SHALL never exceed DATA_W, and its arithmetic SHALL be unsigned CNT_W-bit with no wrap.
REQ-027 Count SHALL remain stable from DONE until the next accepted Start.

Reset
REQ-028 Reset=1 at a rising edge SHALL force IDLE, Count=0, Done=0, Busy=0, and clear the shift and mode registers.
REQ-029 Reset SHALL have priority over Start and over any SCAN progress.
REQ-030 A reset mid-SCAN SHALL abort the operation with no Done pulse.
REQ-031 Outputs SHALL be driven, never tri-stated, in all states including reset.

Structure
REQ-032 The mode encodings and the FSM state type SHALL be placed in the shared package bit_scan_pkg.
REQ-033 One combinational sub-module, chunk_scan, SHALL take a BPC-bit chunk and Mode and return the chunk increment and a found-one flag.
REQ-034 Datapath, FSM and chunk_scan SHALL be sized only by parameters, with no hard-coded widths.

Verification
REQ-035 With DATA_W=8, BPC=2, mode 00 and DataIn=0xB5, the bench SHALL check N=4 and Done five cycles after the Start edge with Count=5.
REQ-036 With mode 01 and DataIn=0xB5, the bench SHALL check Count=3 and N=4; with DataIn=0x00 in mode 00, it SHALL check Count=0 and N=1.
REQ-037 With mode 11 and DataIn=0x28, the bench SHALL check Count=3 and N=2; with mode 10 and DataIn=0x28, it SHALL check Count=2 and N=2.
REQ-038 With modes 10 and 11 and DataIn=0x00, the bench SHALL check Count=8 and N=4.
REQ-039 A Start pulse with a new DataIn during SCAN SHALL be shown to be ignored, with the original result unchanged.
REQ-040 Reset asserted in SCAN cycle 2 SHALL be shown to give IDLE next cycle with Count=0 and no Done, and a following Start SHALL complete normally.
REQ-041 The scenarios SHALL be repeated at BPC=1 and BPC=4 with the same Count values and N scaled accordingly.

Source files
------------

// File: rtl/bit_scan_pkg.sv
// Shared types for the bit scan counter: mode encodings and FSM states.
package bit_scan_pkg;

    typedef enum logic [1:0] {
        MODE_ONES  = 2'b00,
        MODE_ZEROS = 2'b01,
        MODE_LEAD  = 2'b10,
        MODE_TRAIL = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SCAN = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/chunk_scan.sv
// Combinational evaluation of one BPC-bit chunk: the amount it adds to the
// running count for the selected mode, plus whether it contains any 1.
module chunk_scan
    import bit_scan_pkg::*;
#(
    parameter int BPC   = 1,
    parameter int INC_W = $clog2(BPC + 1)
) (
    input  logic [BPC-1:0]   chunk,
    input  mode_e            mode,
    output logic [INC_W-1:0] inc,
    output logic             found_one
);

    logic [INC_W-1:0] ones;
    logic [INC_W-1:0] lead;
    logic [INC_W-1:0] trail;
    logic             lead_seen;
    logic             trail_seen;

    // Popcount plus zero runs from each end of the chunk, stopping at the first 1.
    always_comb begin
        ones       = '0;
        lead       = '0;
        trail      = '0;
        lead_seen  = 1'b0;
        trail_seen = 1'b0;
        for (int i = 0; i < BPC; i++) begin
            ones = ones + INC_W'(chunk[i]);
            if (!trail_seen) begin
                if (chunk[i]) begin
                    trail_seen = 1'b1;
                end else begin
                    trail = trail + INC_W'(1);
                end
            end
            if (!lead_seen) begin
                if (chunk[BPC-1-i]) begin
                    lead_seen = 1'b1;
                end else begin
                    lead = lead + INC_W'(1);
                end
            end
        end
    end

    // Pick the increment that matches the mode's counting rule.
    always_comb begin
        case (mode)
            MODE_ONES:  inc = ones;
            MODE_ZEROS: inc = INC_W'(BPC) - ones;
            MODE_LEAD:  inc = lead;
            default:    inc = trail;
        endcase
    end

    assign found_one = |chunk;

endmodule

// File: rtl/bit_scan_counter.sv
// Multi-cycle bit counter: captures an operand, walks it BPC bits per cycle
// and accumulates ones, zeros, leading zeros or trailing zeros.
module bit_scan_counter
    import bit_scan_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int BPC    = 1,
    parameter int CNT_W  = $clog2(DATA_W + 1)
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              Start,
    input  logic [1:0]        Mode,
    input  logic [DATA_W-1:0] DataIn,
    output logic              Busy,
    output logic              Done,
    output logic [CNT_W-1:0]  Count
);

    localparam int NCHUNK = DATA_W / BPC;
    localparam int CHK_W  = $clog2(NCHUNK + 1);
    localparam int INC_W  = $clog2(BPC + 1);
    localparam int SUM_W  = CNT_W + 1;

    state_e            state_q, state_d;
    mode_e             mode_q, mode_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CHK_W-1:0]  chunk_cnt_q, chunk_cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [BPC-1:0]    chunk;
    logic [DATA_W-1:0] shifted;
    logic [INC_W-1:0]  inc;
    logic              found_one;
    logic [SUM_W-1:0]  sum;
    logic [CNT_W-1:0]  count_next;
    logic              last_chunk;
    logic              early_exit;

    // Leading-zero mode consumes from the top, every other mode from the bottom.
    always_comb begin
        if (mode_q == MODE_LEAD) begin
            chunk   = shift_q[DATA_W-1 -: BPC];
            shifted = shift_q << BPC;
        end else begin
            chunk   = shift_q[BPC-1:0];
            shifted = shift_q >> BPC;
        end
    end

    chunk_scan #(
        .BPC   (BPC),
        .INC_W (INC_W)
    ) u_chunk_scan (
        .chunk     (chunk),
        .mode      (mode_q),
        .inc       (inc),
        .found_one (found_one)
    );

    // Accumulate with one spare bit and clamp so the result can never exceed DATA_W.
    always_comb begin
        sum = SUM_W'(count_q) + SUM_W'(inc);
        if (sum > SUM_W'(DATA_W)) begin
            count_next = CNT_W'(DATA_W);
        end else begin
            count_next = sum[CNT_W-1:0];
        end
    end

    // Termination: all chunks consumed, or the mode's early-out condition is met.
    always_comb begin
        last_chunk = (chunk_cnt_q == CHK_W'(NCHUNK - 1));
        case (mode_q)
            MODE_ONES:  early_exit = (shifted == '0);
            MODE_ZEROS: early_exit = 1'b0;
            default:    early_exit = found_one;
        endcase
    end

    // Next-state and next-output logic; Busy and Done are computed here and registered.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        shift_d     = shift_q;
        count_d     = count_q;
        chunk_cnt_d = chunk_cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    shift_d     = DataIn;
                    mode_d      = mode_e'(Mode);
                    count_d     = '0;
                    chunk_cnt_d = '0;
                    busy_d      = 1'b1;
                    state_d     = ST_SCAN;
                end
            end
            ST_SCAN: begin
                shift_d     = shifted;
                count_d     = count_next;
                chunk_cnt_d = chunk_cnt_q + CHK_W'(1);
                if (last_chunk || early_exit) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register; reset wins over Start and over any scan progress.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_ONES;
            shift_q     <= '0;
            count_q     <= '0;
            chunk_cnt_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            shift_q     <= shift_d;
            count_q     <= count_d;
            chunk_cnt_q <= chunk_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign Busy  = busy_q;
    assign Done  = done_q;
    assign Count = count_q;

endmodule

// File: tb/tb_bit_scan_counter.sv
// Bench for bit_scan_counter at DATA_W=8 with BPC=1, 2 and 4 side by side.
module tb_bit_scan_counter;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;
    localparam int NDUT   = 3;
    localparam int BUDGET = 24;
    localparam int LEAD28_N [NDUT] = '{3, 2, 1};

    logic              clk = 1'b0;
    logic              reset_s [NDUT];
    logic              start_s [NDUT];
    logic [1:0]        mode_s  [NDUT];
    logic [DATA_W-1:0] data_s  [NDUT];
    logic              busy_s  [NDUT];
    logic              done_s  [NDUT];
    logic [CNT_W-1:0]  count_s [NDUT];

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        bit_scan_counter #(
            .DATA_W (DATA_W),
            .BPC    (1 << g),
            .CNT_W  (CNT_W)
        ) u_dut (
            .CLK    (clk),
            .Reset  (reset_s[g]),
            .Start  (start_s[g]),
            .Mode   (mode_s[g]),
            .DataIn (data_s[g]),
            .Busy   (busy_s[g]),
            .Done   (done_s[g]),
            .Count  (count_s[g])
        );
    end

    function automatic int leadZeros(input logic [DATA_W-1:0] data);
        int n = DATA_W;
        for (int i = 0; i < DATA_W; i++) begin
            if (data[DATA_W-1-i] && n == DATA_W) n = i;
        end
        return n;
    endfunction

    function automatic int trailZeros(input logic [DATA_W-1:0] data);
        int n = DATA_W;
        for (int i = 0; i < DATA_W; i++) begin
            if (data[i] && n == DATA_W) n = i;
        end
        return n;
    endfunction

    function automatic int refCount(input logic [1:0] mode, input logic [DATA_W-1:0] data);
        int ones = $countones(data);
        case (mode)
            2'b00:   return ones;
            2'b01:   return DATA_W - ones;
            2'b10:   return leadZeros(data);
            default: return trailZeros(data);
        endcase
    endfunction

    function automatic int refCycles(input logic [1:0] mode, input logic [DATA_W-1:0] data, input int bpc);
        int nch = DATA_W / bpc;
        int hi  = 0;
        for (int i = 0; i < DATA_W; i++) begin
            if (data[i]) hi = i;
        end
        case (mode)
            2'b00:   return (data == '0) ? 1 : hi / bpc + 1;
            2'b01:   return nch;
            2'b10:   return (data == '0) ? nch : leadZeros(data) / bpc + 1;
            default: return (data == '0) ? nch : trailZeros(data) / bpc + 1;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input int d, input logic [31:0] observed, input logic [31:0] expected);
        n_asserts++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s bpc=%0d observed=%0d expected=%0d", tag, 1 << d, observed, expected);
        end
    endtask

    // Starts one operation and returns the SCAN length; returns at the Done cycle.
    task automatic applyStimulus(input int d, input logic [1:0] mode, input logic [DATA_W-1:0] data,
                                 input bit poke, output int n_obs);
        @(negedge clk);
        mode_s[d]  = mode;
        data_s[d]  = data;
        start_s[d] = 1'b1;
        @(negedge clk);
        checkOutput("busy_in_scan", d, busy_s[d], 1);
        if (poke) begin
            data_s[d] = ~data;
            mode_s[d] = mode ^ 2'b01;
        end else begin
            start_s[d] = 1'b0;
        end
        n_obs = -1;
        for (int c = 1; c <= BUDGET && n_obs < 0; c++) begin
            if (done_s[d] === 1'b1) begin
                n_obs = c - 1;
            end else begin
                @(negedge clk);
                start_s[d] = 1'b0;
            end
        end
        if (n_obs < 0) checkOutput("done_timeout", d, 0, 1);
    endtask

    task automatic runCase(input int d, input logic [1:0] mode, input logic [DATA_W-1:0] data,
                           input int exp_count, input int exp_n);
        int n_obs;
        applyStimulus(d, mode, data, 1'b0, n_obs);
        checkOutput("count", d, count_s[d], exp_count);
        checkOutput("scan_cycles", d, n_obs, exp_n);
        @(negedge clk);
        checkOutput("done_one_cycle", d, done_s[d], 0);
        checkOutput("busy_after_done", d, busy_s[d], 0);
        checkOutput("count_held", d, count_s[d], exp_count);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int               n_obs;
        int               nch;
        logic             seen_done;
        logic [1:0]       rmode;
        logic [DATA_W-1:0] rdata;

        for (int d = 0; d < NDUT; d++) begin
            reset_s[d] = 1'b1;
            start_s[d] = 1'b0;
            mode_s[d]  = 2'b00;
            data_s[d]  = '0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < NDUT; d++) reset_s[d] = 1'b0;
        @(negedge clk);

        $display("[TB] reset state");
        for (int d = 0; d < NDUT; d++) begin
            checkOutput("reset_busy", d, busy_s[d], 0);
            checkOutput("reset_done", d, done_s[d], 0);
            checkOutput("reset_count", d, count_s[d], 0);
        end

        $display("[TB] directed cases");
        for (int d = 0; d < NDUT; d++) begin
            nch = DATA_W >> d;
            runCase(d, 2'b00, 8'hB5, 5, nch);
            runCase(d, 2'b01, 8'hB5, 3, nch);
            runCase(d, 2'b00, 8'h00, 0, 1);
            runCase(d, 2'b11, 8'h28, 3, 4 >> d);
            runCase(d, 2'b10, 8'h28, 2, LEAD28_N[d]);
            runCase(d, 2'b10, 8'h00, 8, nch);
            runCase(d, 2'b11, 8'h00, 8, nch);
        end

        $display("[TB] start ignored during scan and done");
        for (int d = 0; d < NDUT; d++) begin
            applyStimulus(d, 2'b00, 8'hB5, 1'b1, n_obs);
            checkOutput("poke_count", d, count_s[d], 5);
            checkOutput("poke_cycles", d, n_obs, DATA_W >> d);
            start_s[d] = 1'b1;
            data_s[d]  = 8'hFF;
            mode_s[d]  = 2'b01;
            @(negedge clk);
            start_s[d] = 1'b0;
            checkOutput("start_in_done_busy", d, busy_s[d], 0);
            checkOutput("start_in_done_done", d, done_s[d], 0);
            checkOutput("start_in_done_count", d, count_s[d], 5);
            @(negedge clk);
            checkOutput("idle_after_done_busy", d, busy_s[d], 0);
        end

        $display("[TB] reset during scan");
        for (int d = 0; d < NDUT; d++) begin
            @(negedge clk);
            mode_s[d]  = 2'b01;
            data_s[d]  = 8'hB5;
            start_s[d] = 1'b1;
            @(negedge clk);
            start_s[d] = 1'b0;
            seen_done  = done_s[d];
            @(negedge clk);
            checkOutput("scan2_busy", d, busy_s[d], 1);
            seen_done  = seen_done | done_s[d];
            reset_s[d] = 1'b1;
            @(negedge clk);
            reset_s[d] = 1'b0;
            checkOutput("abort_busy", d, busy_s[d], 0);
            checkOutput("abort_done", d, done_s[d], 0);
            checkOutput("abort_count", d, count_s[d], 0);
            for (int c = 0; c < 10; c++) begin
                seen_done = seen_done | done_s[d];
                @(negedge clk);
            end
            checkOutput("abort_no_done", d, seen_done, 0);
            runCase(d, 2'b01, 8'hB5, 3, DATA_W >> d);
        end

        $display("[TB] random cases");
        for (int d = 0; d < NDUT; d++) begin
            for (int k = 0; k < 16; k++) begin
                rmode = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 3) == 0) begin
                    rdata = DATA_W'(1) << $urandom_range(0, DATA_W - 1);
                end else begin
                    rdata = DATA_W'($urandom_range(0, 255));
                end
                runCase(d, rmode, rdata, refCount(rmode, rdata), refCycles(rmode, rdata, 1 << d));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
